// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read forwarding and a per-register pending scoreboard for RAW stalls.

module reg_file_sb_entry #(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              set,
  input  logic              clr,
  input  logic              flush,
  output logic [DATA_W-1:0] q,
  output logic              pend,
  output logic              pend_d
);

  // A fresh issue outranks a retiring writer to the same register.
  always_comb begin
    pend_d = pend;
    if (flush)    pend_d = 1'b0;
    else if (set) pend_d = 1'b1;
    else if (clr) pend_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= RST_VAL;
      pend <= 1'b0;
    end else begin
      if (wr) q <= wdata;
      pend <= pend_d;
    end
  end

endmodule

module reg_file_sb #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int BYPASS     = 1,
  parameter int RESET_BASE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  output logic [DATA_W-1:0] sr1_out,
  output logic [DATA_W-1:0] sr2_out,
  output logic              sr1_busy,
  output logic              sr2_busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] dr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dr,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit BYP   = (BYPASS != 0);

  logic [DEPTH-1:0][DATA_W-1:0] rf_q;
  logic [DEPTH-1:0]             pend_q;
  logic [DEPTH-1:0]             pend_d;
  logic [ADDR_W:0]              cnt_d;
  logic                         hit1, hit2;

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    localparam logic [DATA_W-1:0] RV = DATA_W'(RESET_BASE + g);

    reg_file_sb_entry #(
      .DATA_W  (DATA_W),
      .RST_VAL (RV)
    ) u_ent (
      .clk    (clk),
      .rst    (rst),
      .wr     (we && (dr == ADDR_W'(g))),
      .wdata  (data_in),
      .set    (issue_en && (issue_dr == ADDR_W'(g))),
      .clr    (we && (dr == ADDR_W'(g))),
      .flush  (flush),
      .q      (rf_q[g]),
      .pend   (pend_q[g]),
      .pend_d (pend_d[g])
    );
  end

  // Forwarding is suppressed while reset is held: that write will never land.
  assign hit1 = BYP && !rst && we && (dr == sr1);
  assign hit2 = BYP && !rst && we && (dr == sr2);

  assign sr1_out  = hit1 ? data_in : rf_q[sr1];
  assign sr2_out  = hit2 ? data_in : rf_q[sr2];
  assign sr1_busy = pend_q[sr1] && !hit1;
  assign sr2_busy = pend_q[sr2] && !hit2;

  // Count is taken from next-state pending so it tracks the bits edge for edge.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_count <= '0;
    else     busy_count <= cnt_d;
  end

endmodule
